// File: rtl/oracle_query_ctrl.sv
// oracle_query_ctrl
//   Sequencer that drives one sequential benchmark core as a black-box oracle.
//   It collects a query (up to DEPTH input vectors), holds the core in reset
//   for RSTCYC cycles, applies one vector per clock and captures the core
//   response to each vector. The responses are then streamed back over a
//   valid/ready port.
//
// Ports
//   CK, RN                 clock (rising edge) and asynchronous active-low reset
//   vec_valid/ready/data/last  query vector input stream
//   res_valid/ready/data/last  response output stream
//   core_rst_n, core_in    drive the core's flop reset and primary inputs
//   core_out               core primary outputs
//   busy                   high while resetting, running or draining
//   err_ovf                sticky; set when a query fills the buffer without
//                          vec_last, cleared when the next query starts
//
// Configuration
//   ORACLE_MISR_EN  when defined, RUN folds every core sample into an
//                   NOUT-bit MISR, the buffer keeps the query vectors, and
//                   DRAIN emits a single beat holding the signature.
module oracle_query_ctrl #(
   parameter int NIN    = 3,
   parameter int NOUT   = 6,
   parameter int DEPTH  = 16,
   parameter int RSTCYC = 2
) (
   input  logic            CK,
   input  logic            RN,
   input  logic            vec_valid,
   output logic            vec_ready,
   input  logic [NIN-1:0]  vec_data,
   input  logic            vec_last,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [NOUT-1:0] res_data,
   output logic            res_last,
   output logic            core_rst_n,
   output logic [NIN-1:0]  core_in,
   input  logic [NOUT-1:0] core_out,
   output logic            busy,
   output logic            err_ovf
);
   localparam int CW  = $clog2(DEPTH) + 1;
   localparam int AW  = $clog2(DEPTH);
   localparam int BW  = (NIN > NOUT) ? NIN : NOUT;
   localparam int RCW = (RSTCYC > 1) ? $clog2(RSTCYC) : 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RST, S_RUN, S_DRAIN} state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   len_reg, len_next;
   logic [CW-1:0]   idx_reg, idx_next, idx_m1;
   logic [RCW-1:0]  rst_cnt_reg, rst_cnt_next;
   logic            err_ovf_reg, err_ovf_next;
   logic            vec_ready_reg, vec_ready_next;
   logic            res_valid_reg, res_valid_next;
   logic [NOUT-1:0] res_data_reg, res_data_next;
   logic            res_last_reg, res_last_next;
   logic            core_rst_n_reg, core_rst_n_next;
   logic [NIN-1:0]  core_in_reg, core_in_next;
   logic            busy_reg, busy_next;
   logic            accept;

   // Query buffer: holds the vectors, then (per-vector mode) the responses.
   logic [BW-1:0]   mem [DEPTH];
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [BW-1:0]   wr_data;

`ifdef ORACLE_MISR_EN
   logic [NOUT-1:0] sig_reg, sig_next;
`endif

   assign accept = vec_valid & vec_ready_reg;
   assign idx_m1 = idx_reg - CW'(1);

   always_comb begin
      state_next    = state_reg;
      len_next      = len_reg;
      idx_next      = idx_reg;
      rst_cnt_next  = rst_cnt_reg;
      err_ovf_next  = err_ovf_reg;
      res_valid_next = res_valid_reg;
      res_data_next = res_data_reg;
      res_last_next = res_last_reg;
      wr_en         = 1'b0;
      wr_addr       = len_reg[AW-1:0];
      wr_data       = BW'(vec_data);
`ifdef ORACLE_MISR_EN
      sig_next      = sig_reg;
`endif
      case (state_reg)
         S_IDLE: begin
            if (accept) begin
               wr_en        = 1'b1;
               wr_addr      = '0;
               len_next     = CW'(1);
               err_ovf_next = 1'b0;
               rst_cnt_next = '0;
               state_next   = vec_last ? S_RST : S_LOAD;
            end
         end
         S_LOAD: begin
            if (accept) begin
               wr_en    = 1'b1;
               len_next = len_reg + CW'(1);
               if (vec_last) begin
                  state_next   = S_RST;
                  rst_cnt_next = '0;
               end else if (len_reg == CW'(DEPTH - 1)) begin
                  // Buffer full without a last marker: run what we have.
                  err_ovf_next = 1'b1;
                  state_next   = S_RST;
                  rst_cnt_next = '0;
               end
            end
         end
         S_RST: begin
            if (rst_cnt_reg == RCW'(RSTCYC - 1)) begin
               state_next = S_RUN;
               idx_next   = '0;
`ifdef ORACLE_MISR_EN
               sig_next   = '0;
`endif
            end else begin
               rst_cnt_next = rst_cnt_reg + RCW'(1);
            end
         end
         S_RUN: begin
            // The response to vector k is visible one cycle after it is applied.
            if (idx_reg != '0) begin
`ifdef ORACLE_MISR_EN
               sig_next = {sig_reg[NOUT-2:0], sig_reg[NOUT-1] ^ sig_reg[0]} ^ core_out;
`else
               wr_en   = 1'b1;
               wr_addr = idx_m1[AW-1:0];
               wr_data = BW'(core_out);
`endif
            end
            if (idx_reg == len_reg) begin
               state_next     = S_DRAIN;
               idx_next       = '0;
               res_valid_next = 1'b1;
`ifdef ORACLE_MISR_EN
               res_data_next  = sig_next;
               res_last_next  = 1'b1;
`else
               // Entry 0 is being written this very cycle when len is 1.
               res_data_next  = (len_reg == CW'(1)) ? core_out : mem[AW'(0)][NOUT-1:0];
               res_last_next  = (len_reg == CW'(1));
`endif
            end else begin
               idx_next = idx_reg + CW'(1);
            end
         end
         S_DRAIN: begin
            if (res_ready) begin
               if (res_last_reg) begin
                  state_next     = S_IDLE;
                  res_valid_next = 1'b0;
                  res_last_next  = 1'b0;
               end else begin
                  idx_next      = idx_reg + CW'(1);
                  res_data_next = mem[idx_next[AW-1:0]][NOUT-1:0];
                  res_last_next = (idx_next == len_reg - CW'(1));
               end
            end
         end
         default: state_next = S_IDLE;
      endcase

      // Control outputs are registered copies of what the next state implies.
      vec_ready_next  = (state_next == S_IDLE) || (state_next == S_LOAD);
      busy_next       = !vec_ready_next;
      core_rst_n_next = (state_next != S_RST);
      core_in_next    = '0;
      if ((state_next == S_RUN) && (idx_next < len_reg))
         core_in_next = mem[idx_next[AW-1:0]][NIN-1:0];
   end

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         state_reg      <= S_IDLE;
         len_reg        <= '0;
         idx_reg        <= '0;
         rst_cnt_reg    <= '0;
         err_ovf_reg    <= 1'b0;
         vec_ready_reg  <= 1'b0;
         res_valid_reg  <= 1'b0;
         res_data_reg   <= '0;
         res_last_reg   <= 1'b0;
         core_rst_n_reg <= 1'b0;
         core_in_reg    <= '0;
         busy_reg       <= 1'b0;
`ifdef ORACLE_MISR_EN
         sig_reg        <= '0;
`endif
      end else begin
         state_reg      <= state_next;
         len_reg        <= len_next;
         idx_reg        <= idx_next;
         rst_cnt_reg    <= rst_cnt_next;
         err_ovf_reg    <= err_ovf_next;
         vec_ready_reg  <= vec_ready_next;
         res_valid_reg  <= res_valid_next;
         res_data_reg   <= res_data_next;
         res_last_reg   <= res_last_next;
         core_rst_n_reg <= core_rst_n_next;
         core_in_reg    <= core_in_next;
         busy_reg       <= busy_next;
`ifdef ORACLE_MISR_EN
         sig_reg        <= sig_next;
`endif
      end
   end

   always_ff @(posedge CK) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
   end

   assign vec_ready  = vec_ready_reg;
   assign res_valid  = res_valid_reg;
   assign res_data   = res_data_reg;
   assign res_last   = res_last_reg;
   assign core_rst_n = core_rst_n_reg;
   assign core_in    = core_in_reg;
   assign busy       = busy_reg;
   assign err_ovf    = err_ovf_reg;
endmodule

// File: tb/tb_oracle_query_ctrl.sv
// tb_oracle_query_ctrl
//   Drives random queries into oracle_query_ctrl, which is connected to a
//   small sequential "core" modelled in the bench. Expected responses come
//   from replaying each query through the core step function and are queued;
//   a monitor pops and compares on every response handshake.
module tb_oracle_query_ctrl;
   localparam int NIN = 3, NOUT = 6, DEPTH = 16, RSTCYC = 2;

   logic            CK = 1'b0, RN = 1'b0;
   logic            vec_valid, vec_ready, vec_last;
   logic [NIN-1:0]  vec_data;
   logic            res_valid, res_ready, res_last;
   logic [NOUT-1:0] res_data;
   logic            core_rst_n, busy, err_ovf;
   logic [NIN-1:0]  core_in;
   logic [NOUT-1:0] core_out;

   typedef struct packed {
      logic [NOUT-1:0] data;
      logic            last;
   } beat_t;

   beat_t          exp_q[$];
   logic [NIN-1:0] vecs[$];
   int             n_checks = 0;
   int             n_fail   = 0;
   logic           stall_req = 1'b0;
   logic [NOUT-1:0] core_s = '0;

   always #5 CK = ~CK;

   oracle_query_ctrl #(.NIN(NIN), .NOUT(NOUT), .DEPTH(DEPTH), .RSTCYC(RSTCYC)) dut (
      .CK(CK), .RN(RN),
      .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data), .vec_last(vec_last),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
      .core_rst_n(core_rst_n), .core_in(core_in), .core_out(core_out),
      .busy(busy), .err_ovf(err_ovf)
   );

   // Toy sequential core: state advances each clock, output is the state.
   function automatic logic [NOUT-1:0] core_step(input logic [NOUT-1:0] s, input logic [NIN-1:0] i);
      return {s[4:0], s[5] ^ s[4]} ^ {s[0] & i[2], 2'b00, i};
   endfunction

   always @(posedge CK) begin
      if (!core_rst_n) core_s <= '0;
      else             core_s <= core_step(core_s, core_in);
   end
   assign core_out = core_s;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: reset core, apply the (possibly truncated) query, record outputs.
   task automatic push_expected();
      int n = (vecs.size() > DEPTH) ? DEPTH : vecs.size();
      logic [NOUT-1:0] s = '0;
      logic [NOUT-1:0] sig = '0;
      beat_t b;
      for (int k = 0; k < n; k++) begin
         s = core_step(s, vecs[k]);
`ifdef ORACLE_MISR_EN
         sig = {sig[NOUT-2:0], sig[NOUT-1] ^ sig[0]} ^ s;
`else
         b.data = s;
         b.last = (k == n - 1);
         exp_q.push_back(b);
`endif
      end
`ifdef ORACLE_MISR_EN
      b.data = sig;
      b.last = 1'b1;
      exp_q.push_back(b);
`endif
   endtask

   // Response side: random backpressure, optional 5-cycle stall, compare.
   initial begin
      logic [NOUT-1:0] snap_d;
      logic            snap_l;
      beat_t           e;
      res_ready = 1'b0;
      forever begin
         @(negedge CK);
         if (stall_req && res_valid) begin
            snap_d    = res_data;
            snap_l    = res_last;
            res_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
               @(negedge CK);
               chk("stall_valid", res_valid, 1);
               chk("stall_data", res_data, snap_d);
               chk("stall_last", res_last, snap_l);
            end
            stall_req = 1'b0;
         end
         res_ready = RN && ($urandom_range(0, 3) != 0);
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 1, 0);
            end else begin
               e = exp_q.pop_front();
               $display("beat data=%02h last=%0b exp_data=%02h exp_last=%0b", res_data, res_last, e.data, e.last);
               chk("res_data", res_data, e.data);
               chk("res_last", res_last, e.last);
            end
         end
      end
   end

   task automatic send_vec(input logic [NIN-1:0] v, input logic l);
      int w = 0;
      @(negedge CK);
      vec_valid = 1'b1;
      vec_data  = v;
      vec_last  = l;
      while (!vec_ready && w < 50) begin
         @(negedge CK);
         w++;
      end
      if (!vec_ready) chk("accept_timeout", vec_ready, 1);
      @(posedge CK);
      #1;
      vec_valid = 1'b0;
      vec_last  = 1'b0;
   endtask

   task automatic run_query(input bit use_last, input bit hold_valid);
      int n = vecs.size();
      int cnt = 0;
      int w = 0;
      for (int i = 0; i < n; i++) send_vec(vecs[i], use_last && (i == n - 1));
      push_expected();
      $display("query len=%0d last=%0b hold_valid=%0b", n, use_last, hold_valid);
      if (hold_valid) vec_valid = 1'b1;
      @(negedge CK);
      chk("err_ovf", err_ovf, use_last ? 0 : 1);
      while (core_rst_n == 1'b0 && w < 20) begin
         cnt++;
         if (hold_valid) chk("ready_in_rst", vec_ready, 0);
         @(negedge CK);
         w++;
      end
      chk("rst_low_cycles", cnt, RSTCYC);
      chk("run0_core_in", core_in, vecs[0]);
      w = 0;
      while ((busy || exp_q.size() != 0) && w < 600) begin
         if (hold_valid && busy) chk("ready_while_busy", vec_ready, 0);
         if (!busy) vec_valid = 1'b0;
         @(negedge CK);
         w++;
      end
      vec_valid = 1'b0;
      chk("query_done", (w < 600), 1);
   endtask

   task automatic fill_random(input int n);
      vecs.delete();
      for (int i = 0; i < n; i++) vecs.push_back(NIN'($urandom_range(0, 7)));
   endtask

   task automatic check_reset_values();
      chk("rst_vec_ready", vec_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_last", res_last, 0);
      chk("rst_core_rst_n", core_rst_n, 0);
      chk("rst_core_in", core_in, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err_ovf", err_ovf, 0);
   endtask

   initial begin
      int w;
      vec_valid = 1'b0;
      vec_data  = '0;
      vec_last  = 1'b0;
      repeat (3) @(negedge CK);
      check_reset_values();
      RN = 1'b1;
      @(negedge CK);
      chk("ready_after_release", vec_ready, 1);
      chk("idle_busy", busy, 0);

      // Single vector 3'b001 with last
      vecs.delete();
      vecs.push_back(3'b001);
      run_query(1'b1, 1'b0);

      // Random lengths
      repeat (6) begin
         fill_random($urandom_range(1, DEPTH));
         run_query(1'b1, 1'b0);
      end

      // Overflow: DEPTH vectors, no last
      fill_random(DEPTH);
      run_query(1'b0, 1'b0);

      // Exactly DEPTH vectors with last: no overflow flag
      fill_random(DEPTH);
      run_query(1'b1, 1'b0);

      // Stall the response stream for 5 cycles
      stall_req = 1'b1;
      fill_random(4);
      run_query(1'b1, 1'b0);
      chk("stall_done", stall_req, 0);

      // vec_valid held high while busy
      fill_random(5);
      run_query(1'b1, 1'b1);

      // RN pulsed low in RUN cycle 3 of an 8-vector query
      fill_random(8);
      for (int i = 0; i < 8; i++) send_vec(vecs[i], (i == 7));
      $display("query len=8 aborted by RN");
      w = 0;
      @(negedge CK);
      while (core_rst_n == 1'b0 && w < 20) begin
         @(negedge CK);
         w++;
      end
      repeat (3) @(negedge CK);
      chk("abort_busy", busy, 1);
      RN = 1'b0;
      #1;
      check_reset_values();
      @(negedge CK);
      RN = 1'b1;
      fill_random(2);
      run_query(1'b1, 1'b0);

      chk("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
